// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the ID/EX hazard controller:
//   - register-address width and bus type (REG_AWIDTH / reg_abus_t)
//   - sequencer state encodings (HZ_RUN, HZ_LOAD_WAIT, HZ_FLUSH)
//   - hz_ctrl_t: the five pipeline stall/flush enables as one bundle
// Optional feature macro used by the top: HAZARD_PERF_EN.
package hazard_ctrl_pkg;

    localparam int REG_AWIDTH = 5;
    typedef logic [REG_AWIDTH-1:0] reg_abus_t;

    // Plain 2-bit constants so the encodings line up with older netlists.
    localparam logic [1:0] HZ_RUN       = 2'd0;
    localparam logic [1:0] HZ_LOAD_WAIT = 2'd1;
    localparam logic [1:0] HZ_FLUSH     = 2'd2;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_IDLE   = '{default: 1'b0};
    localparam hz_ctrl_t HZ_BUBBLE = '{pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                       idex_stall: 1'b0, idex_flush: 1'b1};
    localparam hz_ctrl_t HZ_FLUSHV = '{pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1,
                                       idex_stall: 1'b0, idex_flush: 1'b1};
    localparam hz_ctrl_t HZ_FREEZE = '{pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                       idex_stall: 1'b1, idex_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles the decoder/EX-side hazard inputs and the stall/flush enables.
//   slave  : the hazard controller (reads ID/EX state, drives enables)
//   master : the pipeline side (drives ID/EX state, reads enables)
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    reg_abus_t id_rs1_addr_i;
    reg_abus_t id_rs2_addr_i;
    logic      id_use_rs1_i;
    logic      id_use_rs2_i;
    reg_abus_t ex_rd_addr_i;
    logic      ex_is_load_i;
    logic      ex_wb_i;
    logic      ex_redirect_i;
    logic      ext_stall_i;

    logic      pc_stall_o;
    logic      ifid_stall_o;
    logic      ifid_flush_o;
    logic      idex_stall_o;
    logic      idex_flush_o;

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_addr_i, ex_is_load_i, ex_wb_i, ex_redirect_i, ext_stall_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o
    );

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_addr_i, ex_is_load_i, ex_wb_i, ex_redirect_i, ext_stall_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o
    );

endinterface

// File: rtl/hazard_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational load-use hazard term.
//   id_rs1/rs2_addr_i, id_use_rs1/rs2_i : source operands of the ID instruction
//   ex_rd_addr_i, ex_is_load_i, ex_wb_i : destination / class of the ID/EX instruction
//   haz_o : ID needs a value that the load in EX has not produced yet
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  reg_abus_t id_rs1_addr_i,
    input  reg_abus_t id_rs2_addr_i,
    input  logic      id_use_rs1_i,
    input  logic      id_use_rs2_i,
    input  reg_abus_t ex_rd_addr_i,
    input  logic      ex_is_load_i,
    input  logic      ex_wb_i,
    output logic      haz_o
);
    logic rs1_hit, rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);

    // x0 is hardwired zero, so a load "to x0" never produces a dependency.
    assign haz_o = ex_is_load_i && ex_wb_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// ID/EX pipeline sequencing controller. Each cycle decides whether PC,
// IF/ID and ID/EX advance, hold or take a bubble, for load-use hazards,
// EX-stage redirects and external (dmem/UART) wait requests.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   hz       : hazard_ctrl_if.slave (hazard inputs, stall/flush enables)
//   stall_cnt_o, flush_cnt_o : 32-bit perf counters, only with HAZARD_PERF_EN
// Parameters: LOAD_BUBBLES (1..3), REDIRECT_FLUSH (1..3), CNT_W holds the max.
// Only state_q/cnt_q (and the perf counters) are registered; enables are
// combinational so the response to any input is zero-cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES   = 1,
    parameter int REDIRECT_FLUSH = 1,
    parameter int CNT_W          = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_if.slave       hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
`endif
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LB_INIT = CNT_W'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] RF_INIT = CNT_W'(REDIRECT_FLUSH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz;
    hz_ctrl_t         ctl;

    hazard_detect u_detect (
        .id_rs1_addr_i (hz.id_rs1_addr_i),
        .id_rs2_addr_i (hz.id_rs2_addr_i),
        .id_use_rs1_i  (hz.id_use_rs1_i),
        .id_use_rs2_i  (hz.id_use_rs2_i),
        .ex_rd_addr_i  (hz.ex_rd_addr_i),
        .ex_is_load_i  (hz.ex_is_load_i),
        .ex_wb_i       (hz.ex_wb_i),
        .haz_o         (haz)
    );

    // Priority: rst > ext stall > redirect / FLUSH > load-use / LOAD_WAIT > run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = HZ_IDLE;
        if (rst) begin
            ctl     = HZ_FLUSHV;
            state_d = HZ_RUN;
            cnt_d   = '0;
        end else if (hz.ext_stall_i) begin
            // Whole pipe frozen; EX inputs persist and get re-evaluated on release.
            ctl = HZ_FREEZE;
        end else if (hz.ex_redirect_i) begin
            // Redirect beats a same-cycle hazard: the dependent instruction is
            // wrong-path, so no bubble is charged. Also covers the (unexpected)
            // redirect seen while in LOAD_WAIT or FLUSH.
            ctl = HZ_FLUSHV;
            if (REDIRECT_FLUSH > 1) begin
                state_d = HZ_FLUSH;
                cnt_d   = RF_INIT;
            end else begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        end else if (state_q == HZ_FLUSH) begin
            // Hazards from discarded instructions are ignored here.
            ctl   = HZ_FLUSHV;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = HZ_RUN;
        end else if (state_q == HZ_LOAD_WAIT) begin
            ctl   = HZ_BUBBLE;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = HZ_RUN;
        end else begin
            // RUN (an unused encoding also lands here and recovers to RUN).
            state_d = HZ_RUN;
            if (haz) begin
                ctl = HZ_BUBBLE;
                if (LOAD_BUBBLES > 1) begin
                    state_d = HZ_LOAD_WAIT;
                    cnt_d   = LB_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_stall_o   = ctl.pc_stall;
    assign hz.ifid_stall_o = ctl.ifid_stall;
    assign hz.ifid_flush_o = ctl.ifid_flush;
    assign hz.idex_stall_o = ctl.idex_stall;
    assign hz.idex_flush_o = ctl.idex_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // ctl is already forced to the flush pattern during reset, but the
    // counters must not count reset cycles, hence the explicit !rst.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ctl.pc_stall   & ~rst};
        flush_cnt_d = flush_cnt_q + {31'd0, ctl.idex_flush & ~rst};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the same stimulus:
// u_a (LOAD_BUBBLES=1, REDIRECT_FLUSH=1) and u_b (LOAD_BUBBLES=3, REDIRECT_FLUSH=2).
// Enables are compared as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [4:0] IDL = 5'b00000;
    localparam logic [4:0] BUB = 5'b11001;
    localparam logic [4:0] FLS = 5'b00101;
    localparam logic [4:0] STL = 5'b11010;

    logic clk = 1'b0;
    logic rst;
    reg_abus_t rs1, rs2, exrd;
    logic use1, use2, ld, wb, redir, ext;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();

    assign if_a.id_rs1_addr_i = rs1;   assign if_b.id_rs1_addr_i = rs1;
    assign if_a.id_rs2_addr_i = rs2;   assign if_b.id_rs2_addr_i = rs2;
    assign if_a.id_use_rs1_i  = use1;  assign if_b.id_use_rs1_i  = use1;
    assign if_a.id_use_rs2_i  = use2;  assign if_b.id_use_rs2_i  = use2;
    assign if_a.ex_rd_addr_i  = exrd;  assign if_b.ex_rd_addr_i  = exrd;
    assign if_a.ex_is_load_i  = ld;    assign if_b.ex_is_load_i  = ld;
    assign if_a.ex_wb_i       = wb;    assign if_b.ex_wb_i       = wb;
    assign if_a.ex_redirect_i = redir; assign if_b.ex_redirect_i = redir;
    assign if_a.ext_stall_i   = ext;   assign if_b.ext_stall_i   = ext;

`ifdef HAZARD_PERF_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    hazard_ctrl #(.LOAD_BUBBLES(1), .REDIRECT_FLUSH(1), .CNT_W(2)) u_a (
        .clk (clk), .rst (rst), .hz (if_a)
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o (sc_a), .flush_cnt_o (fc_a)
`endif
    );

    hazard_ctrl #(.LOAD_BUBBLES(3), .REDIRECT_FLUSH(2), .CNT_W(2)) u_b (
        .clk (clk), .rst (rst), .hz (if_b)
`ifdef HAZARD_PERF_EN
        , .stall_cnt_o (sc_b), .flush_cnt_o (fc_b)
`endif
    );

    logic [4:0] o_a, o_b;
    assign o_a = {if_a.pc_stall_o, if_a.ifid_stall_o, if_a.ifid_flush_o,
                  if_a.idex_stall_o, if_a.idex_flush_o};
    assign o_b = {if_b.pc_stall_o, if_b.ifid_stall_o, if_b.ifid_flush_o,
                  if_b.idex_stall_o, if_b.idex_flush_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare both instances at the negedge, then move to just after the next posedge.
    task automatic step(input string tag, input logic [4:0] ea, input logic [4:0] eb);
        @(negedge clk);
        chk({tag, "/a"}, {27'd0, o_a}, {27'd0, ea});
        chk({tag, "/b"}, {27'd0, o_b}, {27'd0, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rs1 = '0; rs2 = '0; exrd = '0;
        use1 = 0; use2 = 0; ld = 0; wb = 0; redir = 0; ext = 0;
    endtask

    task automatic lw_hit();  // lw x5 in EX, ID reads x5 via rs1
        exrd = 5'd5; ld = 1; wb = 1; rs1 = 5'd5; use1 = 1;
    endtask

    initial begin
        idle_in();
        rst = 1;
        step("reset", FLS, FLS);
        rst = 0;
        step("run_idle", IDL, IDL);

        // Load-use via rs1; after the first bubble EX holds a NOP.
        lw_hit();
        step("lu_c1", BUB, BUB);
        idle_in();
        step("lu_c2", IDL, BUB);
        step("lu_c3", IDL, BUB);
        step("lu_done", IDL, IDL);

        // No-hazard corner cases.
        exrd = 5'd0; rs1 = 5'd0; use1 = 1; ld = 1; wb = 1;
        step("x0", IDL, IDL);
        exrd = 5'd7; rs1 = 5'd0; use1 = 0; rs2 = 5'd7; use2 = 0;
        step("rs2_unused", IDL, IDL);
        ld = 1; wb = 0; use2 = 1;
        step("load_no_wb", IDL, IDL);
        ld = 0; wb = 1;
        step("not_load", IDL, IDL);

        // rs2 hazard, then ext stall for 4 cycles while u_b sits in LOAD_WAIT cnt=2.
        ld = 1; wb = 1;
        step("rs2_haz", BUB, BUB);
        idle_in();
        ext = 1;
        for (int i = 0; i < 4; i++) step("ext_hold", STL, STL);
        ext = 0;
        step("ext_rel1", IDL, BUB);
        step("ext_rel2", IDL, BUB);
        step("ext_done", IDL, IDL);

        // Redirect together with a hazard: redirect wins, no bubble.
        lw_hit(); redir = 1;
        step("redir_haz", FLS, FLS);
        idle_in();
        step("redir_f2", IDL, FLS);
        step("redir_done", IDL, IDL);

        // Redirect frozen by ext stall: flush cycles exclude the stalled ones.
        redir = 1; ext = 1;
        step("redir_ext1", STL, STL);
        step("redir_ext2", STL, STL);
        ext = 0;
        step("redir_go", FLS, FLS);
        redir = 0;
        step("redir_go2", IDL, FLS);
        step("redir_go3", IDL, IDL);

        // Reset while u_b is in FLUSH with cnt=1 aborts the flush.
        redir = 1;
        step("pre_rst", FLS, FLS);
        redir = 0; rst = 1;
        step("rst_mid", FLS, FLS);
        rst = 0;
        step("post_rst", IDL, IDL);

        // Reset in LOAD_WAIT also aborts.
        lw_hit();
        step("lw_pre", BUB, BUB);
        idle_in(); rst = 1;
        step("lw_rst", FLS, FLS);
        rst = 0;
        step("lw_post", IDL, IDL);

`ifdef HAZARD_PERF_EN
        rst = 1;
        step("perf_rst", FLS, FLS);
        rst = 0;
        lw_hit();
        for (int i = 0; i < 3; i++) step("perf_lu", BUB, BUB);
        idle_in(); redir = 1;
        step("perf_redir", FLS, FLS);
        redir = 0;
        step("perf_f2", IDL, FLS);
        @(negedge clk);
        chk("stall_cnt/a", sc_a, 32'd3);
        chk("flush_cnt/a", fc_a, 32'd4);
        chk("stall_cnt/b", sc_b, 32'd3);
        chk("flush_cnt/b", fc_b, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
